tpu_axil_regfile: RTL and testbench

TPU_AXIL_REGFILE -- requirements
Module: tpu_axil_regfile

---
 rtl/tpu_axil_regfile.sv | 203 ++++++++++++++++++++
 tb/tb_tpu_axil_regfile.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_axil_regfile.sv
// AXI4-Lite register file for a TPU core: CTRL/STATUS plus plain configuration registers,
// with independent AW/W buffering, a one-cycle start pulse and a level interrupt.
module tpu_axil_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 8
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic                                   start_pulse_o,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_o,
    input  logic                                   busy_i,
    input  logic                                   done_i,
    output logic                                   irq_o
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int NB  = DW / 8;
    localparam int LSB = $clog2(NB);
    // One spare index bit so NUM_REGS itself is representable in range compares.
    localparam int IW  = AW - LSB + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          r_ready_en;
    logic          r_aw_held;
    logic [AW-1:LSB] r_awaddr;
    logic          r_w_held;
    logic [DW-1:0] r_wdata;
    logic [NB-1:0] r_wstrb;
    logic          r_bvalid;
    logic [1:0]    r_bresp;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_rresp;
    logic [DW-1:0] r_regs [NUM_REGS];
    logic          r_done;
    logic          r_start;
    logic          r_irq;

    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_aw_fire;
    logic          w_w_fire;
    logic          w_ar_fire;
    logic          w_commit;
    logic          w_w1c;
    logic          w_start_req;
    logic [DW-1:0] w_status;
    logic [DW-1:0] w_wr_old;
    logic [DW-1:0] w_wr_merged;
    logic [DW-1:0] w_rd_value;
    logic          w_unused_addr_bits;

    assign w_unused_addr_bits = &{1'b0, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

    assign w_wr_idx = {1'b0, r_awaddr};
    assign w_rd_idx = {1'b0, S_AXI_ARADDR[AW-1:LSB]};
    assign w_wr_ok  = (w_wr_idx < IW'(NUM_REGS));
    assign w_rd_ok  = (w_rd_idx < IW'(NUM_REGS));

    assign S_AXI_AWREADY = r_ready_en & ~r_aw_held;
    assign S_AXI_WREADY  = r_ready_en & ~r_w_held;
    assign S_AXI_ARREADY = r_ready_en & ~r_rvalid;

    assign w_aw_fire = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_fire  = S_AXI_WVALID & S_AXI_WREADY;
    assign w_ar_fire = S_AXI_ARVALID & S_AXI_ARREADY;

    // A pending response blocks the commit; the buffers keep their contents meanwhile.
    assign w_commit    = r_aw_held & r_w_held & ~r_bvalid;
    assign w_w1c       = w_commit & (w_wr_idx == IW'(1)) & r_wstrb[0] & r_wdata[1];
    assign w_start_req = w_commit & (w_wr_idx == '0) & r_wstrb[0] & r_wdata[0];

    assign w_status = {{(DW-2){1'b0}}, r_done, busy_i};

    always_comb begin
        w_wr_old   = '0;
        w_rd_value = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_wr_idx == IW'(k)) w_wr_old = r_regs[k];
            if (w_rd_idx == IW'(k)) w_rd_value = (k == 1) ? w_status : r_regs[k];
        end
        w_wr_merged = w_wr_old;
        for (int b = 0; b < NB; b++) begin
            if (r_wstrb[b]) w_wr_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_ready_en <= 1'b0;
            r_aw_held  <= 1'b0;
            r_awaddr   <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_commit) begin
                r_aw_held <= 1'b0;
            end else if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= S_AXI_AWADDR[AW-1:LSB];
            end
            if (w_commit) begin
                r_w_held <= 1'b0;
            end else if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
        end
    end

    // STATUS lives in r_done/busy_i, so slot 1 of the array is never written.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (w_commit && w_wr_ok) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_wr_idx == IW'(k) && k != 1) begin
                    r_regs[k] <= (k == 0) ? {w_wr_merged[DW-1:1], 1'b0} : w_wr_merged;
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_done  <= 1'b0;
            r_start <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_done  <= done_i | (r_done & ~w_w1c);
            r_start <= w_start_req;
            r_irq   <= r_done & r_regs[0][1];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_ok ? w_rd_value : '0;
            r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    always_comb begin
        cfg_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            cfg_o[k*DW +: DW] = (k == 1) ? w_status : r_regs[k];
        end
    end

    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign start_pulse_o = r_start;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_tpu_axil_regfile.sv
// Directed bench for tpu_axil_regfile: bus writes/reads, W-before-AW ordering, start pulse,
// DONE/irq behaviour, out-of-range accesses and reset in the middle of a write.
module tb_tpu_axil_regfile;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 8;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [AW-1:0]   S_AXI_AWADDR;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;
    logic            start_pulse_o;
    logic [NR*DW-1:0] cfg_o;
    logic            busy_i;
    logic            done_i;
    logic            irq_o;

    int checks = 0;
    int errors = 0;
    int startCount = 0;
    logic [31:0] expReg [NR];
    logic        expDone;

    tpu_axil_regfile #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA),
        .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA),
        .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .start_pulse_o(start_pulse_o),
        .cfg_o(cfg_o),
        .busy_i(busy_i),
        .done_i(done_i),
        .irq_o(irq_o)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (start_pulse_o === 1'b1) startCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCfg(input string tag);
        logic [31:0] e;
        for (int k = 0; k < NR; k++) begin
            e = (k == 1) ? {30'b0, expDone, busy_i} : expReg[k];
            checkOutput($sformatf("%s_cfg%0d", tag, k), 64'(cfg_o[k*DW +: DW]), 64'(e));
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axiWrite(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] bresp);
        logic awDone;
        logic wDone;
        awDone = 1'b0;
        wDone  = 1'b0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int c = 0; c < 20 && !(awDone && wDone); c++) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) awDone = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) wDone = 1'b1;
            tick();
            if (awDone) S_AXI_AWVALID = 1'b0;
            if (wDone) S_AXI_WVALID = 1'b0;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        for (int c = 0; c < 20 && !S_AXI_BVALID; c++) tick();
        checkOutput("wr_bvalid", 64'(S_AXI_BVALID), 64'(1));
        bresp = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axiRead(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        for (int c = 0; c < 20 && !S_AXI_ARREADY; c++) tick();
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        for (int c = 0; c < 20 && !S_AXI_RVALID; c++) tick();
        checkOutput("rd_rvalid", 64'(S_AXI_RVALID), 64'(1));
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          startBefore;

        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        busy_i = 1'b0; done_i = 1'b0;
        for (int k = 0; k < NR; k++) expReg[k] = '0;
        expDone = 1'b0;

        $display("[TB] reset state");
        repeat (3) tick();
        checkOutput("rst_awready", 64'(S_AXI_AWREADY), 64'(0));
        checkOutput("rst_wready", 64'(S_AXI_WREADY), 64'(0));
        checkOutput("rst_arready", 64'(S_AXI_ARREADY), 64'(0));
        checkOutput("rst_bvalid", 64'(S_AXI_BVALID), 64'(0));
        checkOutput("rst_rvalid", 64'(S_AXI_RVALID), 64'(0));
        checkOutput("rst_start", 64'(start_pulse_o), 64'(0));
        checkOutput("rst_irq", 64'(irq_o), 64'(0));
        checkOutput("rst_rdata", 64'(S_AXI_RDATA), 64'(0));
        ARESET = 1'b0;
        #1;
        checkOutput("rel_awready_before_edge", 64'(S_AXI_AWREADY), 64'(0));
        tick();
        checkOutput("rel_awready", 64'(S_AXI_AWREADY), 64'(1));
        checkOutput("rel_wready", 64'(S_AXI_WREADY), 64'(1));
        checkOutput("rel_arready", 64'(S_AXI_ARREADY), 64'(1));
        checkCfg("reset");

        $display("[TB] plain register write/readback");
        for (int i = 0; i < 6; i++) begin
            axiWrite(AW'(8 + 4*i), 32'(i + 1), 4'hF, resp);
            checkOutput($sformatf("wr%0d_bresp", i + 2), 64'(resp), 64'(0));
            expReg[i + 2] = 32'(i + 1);
        end
        for (int i = 0; i < 6; i++) begin
            axiRead(AW'(8 + 4*i), rd, resp);
            checkOutput($sformatf("rd%0d_data", i + 2), 64'(rd), 64'(i + 1));
            checkOutput($sformatf("rd%0d_resp", i + 2), 64'(resp), 64'(0));
        end
        checkCfg("rw");

        $display("[TB] W three cycles ahead of AW, partial strobe");
        S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'h3; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        checkOutput("wfirst_wready_held", 64'(S_AXI_WREADY), 64'(0));
        tick();
        checkOutput("wfirst_no_b_1", 64'(S_AXI_BVALID), 64'(0));
        tick();
        checkOutput("wfirst_no_b_2", 64'(S_AXI_BVALID), 64'(0));
        S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        checkOutput("wfirst_no_b_3", 64'(S_AXI_BVALID), 64'(0));
        tick();
        checkOutput("wfirst_bvalid", 64'(S_AXI_BVALID), 64'(1));
        checkOutput("wfirst_bresp", 64'(S_AXI_BRESP), 64'(0));
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("wfirst_single_b%0d", c), 64'(S_AXI_BVALID), 64'(0));
            tick();
        end
        expReg[2] = 32'h0000A5A5;
        axiRead(6'h08, rd, resp);
        checkOutput("wfirst_rd", 64'(rd), 64'h0000A5A5);
        checkCfg("wfirst");

        $display("[TB] CTRL start pulse");
        startBefore = startCount;
        axiWrite(6'h00, 32'h3, 4'hF, resp);
        checkOutput("ctrl_bresp", 64'(resp), 64'(0));
        repeat (3) tick();
        checkOutput("start_pulse_cycles", 64'(startCount - startBefore), 64'(1));
        expReg[0] = 32'h2;
        axiRead(6'h00, rd, resp);
        checkOutput("ctrl_rd", 64'(rd), 64'h2);

        $display("[TB] DONE and interrupt");
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        expDone = 1'b1;
        checkOutput("irq_latency", 64'(irq_o), 64'(0));
        tick();
        checkOutput("irq_set", 64'(irq_o), 64'(1));
        axiRead(6'h04, rd, resp);
        checkOutput("status_done", 64'(rd), 64'h2);
        busy_i = 1'b1;
        axiRead(6'h04, rd, resp);
        checkOutput("status_busy", 64'(rd), 64'h3);
        checkCfg("busy");
        busy_i = 1'b0;

        S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        checkOutput("race_bvalid", 64'(S_AXI_BVALID), 64'(1));
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        checkOutput("race_irq", 64'(irq_o), 64'(1));
        axiRead(6'h04, rd, resp);
        checkOutput("race_done_kept", 64'(rd), 64'h2);

        axiWrite(6'h04, 32'h2, 4'hF, resp);
        expDone = 1'b0;
        tick();
        checkOutput("w1c_irq", 64'(irq_o), 64'(0));
        axiRead(6'h04, rd, resp);
        checkOutput("w1c_status", 64'(rd), 64'h0);
        checkCfg("w1c");

        $display("[TB] out-of-range access");
        axiWrite(6'h20, 32'hDEADBEEF, 4'hF, resp);
        checkOutput("oor_bresp", 64'(resp), 64'h2);
        axiRead(6'h20, rd, resp);
        checkOutput("oor_rdata", 64'(rd), 64'h0);
        checkOutput("oor_rresp", 64'(resp), 64'h2);
        checkCfg("oor");

        $display("[TB] reset during pending write");
        S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        checkOutput("mid_bvalid", 64'(S_AXI_BVALID), 64'(1));
        S_AXI_AWADDR = 6'h14; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        checkOutput("mid_aw_held", 64'(S_AXI_AWREADY), 64'(0));
        ARESET = 1'b1;
        #1;
        for (int k = 0; k < NR; k++) expReg[k] = '0;
        expDone = 1'b0;
        checkOutput("mid_rst_bvalid", 64'(S_AXI_BVALID), 64'(0));
        checkOutput("mid_rst_awready", 64'(S_AXI_AWREADY), 64'(0));
        checkOutput("mid_rst_wready", 64'(S_AXI_WREADY), 64'(0));
        checkOutput("mid_rst_arready", 64'(S_AXI_ARREADY), 64'(0));
        checkOutput("mid_rst_irq", 64'(irq_o), 64'(0));
        checkCfg("midrst");
        tick();
        ARESET = 1'b0;
        tick();
        checkOutput("post_awready", 64'(S_AXI_AWREADY), 64'(1));
        checkOutput("post_bvalid", 64'(S_AXI_BVALID), 64'(0));
        axiWrite(6'h18, 32'h55, 4'hF, resp);
        checkOutput("post_bresp", 64'(resp), 64'(0));
        expReg[6] = 32'h55;
        axiRead(6'h18, rd, resp);
        checkOutput("post_rd18", 64'(rd), 64'h55);
        axiRead(6'h10, rd, resp);
        checkOutput("post_rd10", 64'(rd), 64'h0);
        axiRead(6'h14, rd, resp);
        checkOutput("post_rd14", 64'(rd), 64'h0);
        checkCfg("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
